alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's fixed 4-bit registered ALU.
- Operand width is generic. Operands enter over a valid/ready handshake, pass through two register stages, and leave with a 2×W signed result and status flags.
- Downstream backpressure stalls the pipe without losing data.
- Sits between the operand sequencer and the result writeback / scoreboard logic.

---
 rtl/alu_pipe.sv | 153 +++++++++++++++
 tb/tb_alu_pipe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined signed ALU with valid/ready handshakes on both sides.
// S1 captures operands and opcode; S2 captures the 2W result and status flags.
module alu_pipe #(
    parameter int W   = 4,
    parameter int SHW = $clog2(W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    A,
    input  logic [W-1:0]    B,
    input  logic [3:0]      opcode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  result,
    output logic            flag_z,
    output logic            flag_n,
    output logic            flag_v,
    output logic            flag_err
);
    localparam int RW = 2 * W;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_NEG  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_MAX  = 4'b1100;
    localparam logic [3:0] OP_MIN  = 4'b1101;
    localparam logic [3:0] OP_PASS = 4'b1110;

    logic            s1_valid_q, s1_valid_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic            s2_valid_q, s2_valid_d;
    logic [RW-1:0]   result_q, result_d;
    logic            flag_z_q, flag_z_d, flag_n_q, flag_n_d;
    logic            flag_v_q, flag_v_d, flag_err_q, flag_err_d;

    logic            s1_adv, s2_adv;
    logic signed [W-1:0]  a_s, b_s, sra_w;
    logic signed [RW-1:0] a_x, b_x;
    logic [SHW-1:0]  sh;
    logic [RW-1:0]   res_c;
    logic            err_c, ovf_chk;

    always_comb begin
        a_s     = a_q;
        b_s     = b_q;
        a_x     = {{W{a_q[W-1]}}, a_q};
        b_x     = {{W{b_q[W-1]}}, b_q};
        sh      = b_q[SHW-1:0];
        sra_w   = a_s >>> sh;
        res_c   = '0;
        err_c   = 1'b0;
        ovf_chk = 1'b0;
        // Arithmetic is done at 2W so the stored result is always exact.
        case (op_q)
            OP_ADD:  begin res_c = a_x + b_x; ovf_chk = 1'b1; end
            OP_SUB:  begin res_c = a_x - b_x; ovf_chk = 1'b1; end
            OP_MUL:  res_c = a_x * b_x;
            OP_NEG:  begin res_c = -a_x;      ovf_chk = 1'b1; end
            OP_AND:  res_c = {{W{1'b0}}, a_q & b_q};
            OP_OR:   res_c = {{W{1'b0}}, a_q | b_q};
            OP_XOR:  res_c = {{W{1'b0}}, a_q ^ b_q};
            OP_NOT:  res_c = {{W{1'b0}}, ~a_q};
            OP_SHL:  res_c = {{W{1'b0}}, a_q << sh};
            OP_SHR:  res_c = {{W{1'b0}}, a_q >> sh};
            OP_SRA:  res_c = {{W{sra_w[W-1]}}, sra_w};
            OP_SLT:  res_c = {{(RW-1){1'b0}}, a_s < b_s};
            OP_MAX:  res_c = (a_s > b_s) ? a_x : b_x;
            OP_MIN:  res_c = (a_s < b_s) ? a_x : b_x;
            OP_PASS: res_c = a_x;
            default: err_c = 1'b1;
        endcase
    end

    always_comb begin
        s2_adv     = ~s2_valid_q | out_ready;
        s1_adv     = ~s1_valid_q | s2_adv;
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        flag_z_d   = flag_z_q;
        flag_n_d   = flag_n_q;
        flag_v_d   = flag_v_q;
        flag_err_d = flag_err_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                a_d  = A;
                b_d  = B;
                op_d = opcode;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d   = res_c;
                flag_z_d   = (res_c == '0);
                flag_n_d   = res_c[RW-1];
                // Exact value fits in W+1 bits, so W-bit overflow shows as bit W != bit W-1.
                flag_v_d   = ovf_chk & (res_c[W] ^ res_c[W-1]);
                flag_err_d = err_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
            flag_v_q   <= 1'b0;
            flag_err_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
            flag_v_q   <= flag_v_d;
            flag_err_q <= flag_err_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_v    = flag_v_q;
    assign flag_err  = flag_err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: W=4 instance for function/handshake, W=8 instance for width.
module tb_alu_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] A = '0, B = '0, opcode = '0;
    logic       in_ready, out_valid, flag_z, flag_n, flag_v, flag_err;
    logic [7:0] result;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
    logic [7:0]  A8 = '0, B8 = '0;
    logic [3:0]  opcode8 = '0;
    logic        in_ready8, out_valid8, flag_z8, flag_n8, flag_v8, flag_err8;
    logic [15:0] result8;

    int n_vec = 0;
    int n_bad = 0;

    alu_pipe #(.W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .flag_err(flag_err)
    );

    alu_pipe #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(A8), .B(B8), .opcode(opcode8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .flag_z(flag_z8), .flag_n(flag_n8), .flag_v(flag_v8), .flag_err(flag_err8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags4();
        return {flag_z, flag_n, flag_v, flag_err};
    endfunction

    // Streams n PASS beats with A = a0+k; out_ready held low for the first bp cycles.
    task automatic stream(input int n, input int bp, input int a0, input string tag);
        int sent = 0, got = 0, first_out = -1, last_out = -1, ready_drops = 0;
        logic [3:0] av;
        logic [7:0] ev;
        opcode = 4'b1110;
        B = '0;
        for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
            out_ready = (cyc >= bp);
            in_valid  = (sent < n);
            A         = 4'(a0 + sent);
            #1;
            if (in_valid && !in_ready) ready_drops++;
            if (cyc >= 2 && cyc < bp) begin
                check({tag, "_stall_in_ready"}, in_ready, 1'b0);
                check({tag, "_stall_out_valid"}, out_valid, 1'b1);
                av = 4'(a0);
                check({tag, "_stall_result"}, result, {{4{av[3]}}, av});
            end
            if (out_valid && out_ready) begin
                av = 4'(a0 + got);
                ev = {{4{av[3]}}, av};
                check({tag, "_order"}, result, ev);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check({tag, "_beats_out"}, got, n);
        check({tag, "_drain_empty"}, out_valid, 1'b0);
        if (bp == 0) begin
            check({tag, "_ready_drops"}, ready_drops, 0);
            check({tag, "_first_out_cycle"}, first_out, 2);
            check({tag, "_consecutive"}, last_out - first_out, n - 1);
        end
    endtask

    logic [3:0] sw_op   [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                                4'b1011, 4'b1010, 4'b1100, 4'b1111};
    logic [7:0] sw_res  [9] = '{8'b00000100, 8'b11111000, 8'b11110100, 8'b00000010,
                                8'b00000110, 8'b00000001, 8'b11111111, 8'b00000110, 8'b0};
    // {z, n, v, err}
    logic [3:0] sw_flg  [9] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
                                4'b0000, 4'b0100, 4'b0000, 4'b1001};

    initial begin
        #2;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_result", result, 8'h00);
        check("reset_flags", flags4(), 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Opcode sweep, one beat per cycle.
        A = 4'b1110; B = 4'b0110; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 9);
            if (c < 9) opcode = sw_op[c];
            #1;
            check("sweep_in_ready", in_ready, 1'b1);
            @(posedge clk); #1;
            if (c == 0) begin
                check("sweep_latency_early", out_valid, 1'b0);
            end else begin
                check("sweep_out_valid", out_valid, 1'b1);
                check($sformatf("sweep_result_op%b", sw_op[c-1]), result, sw_res[c-1]);
                check($sformatf("sweep_flags_op%b", sw_op[c-1]), flags4(), sw_flg[c-1]);
            end
        end
        @(posedge clk); #1;
        check("sweep_drained", out_valid, 1'b0);

        // Overflow at W bits.
        A = 4'b0111; B = 4'b0001; opcode = 4'b0000; in_valid = 1'b1;
        @(posedge clk); #1;
        A = 4'b1000; opcode = 4'b0011;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ovf_add_result", result, 8'b00001000);
        check("ovf_add_flags", flags4(), 4'b0010);
        @(posedge clk); #1;
        check("ovf_neg_result", result, 8'b00001000);
        check("ovf_neg_flags", flags4(), 4'b0010);
        @(posedge clk); #1;

        stream(4, 5, 1, "backpressure");
        stream(16, 0, -8, "throughput");

        // W=8 instance.
        A8 = 8'h80; B8 = 8'h80; opcode8 = 4'b0010; in_valid8 = 1'b1;
        @(posedge clk); #1;
        A8 = 8'h7F; B8 = 8'h01; opcode8 = 4'b0000;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("w8_mul_valid", out_valid8, 1'b1);
        check("w8_mul_result", result8, 16'h4000);
        check("w8_mul_v", flag_v8, 1'b0);
        @(posedge clk); #1;
        check("w8_add_result", result8, 16'h0080);
        check("w8_add_v", flag_v8, 1'b1);
        check("w8_add_n", flag_n8, 1'b0);
        @(posedge clk); #1;

        // Reset with the pipe full: outputs clear before any clock edge.
        out_ready = 1'b0; A = 4'd1; B = 4'd1; opcode = 4'b0000; in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_before_reset", out_valid, 1'b1);
        check("full_result", result, 8'h02);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", out_valid, 1'b0);
        check("mid_reset_result", result, 8'h00);
        check("mid_reset_flags", flags4(), 4'b0000);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
